// File: rtl/alu_op_sel.sv
// rtl/alu_op_sel.sv - button/switch front end driving the 2-bit add/subtract unit
//
// alu_op_sel_btn : one push-button channel (2-flop sync, debounce, press detect)
//   clk, rst_n   clock and asynchronous active-low reset
//   raw          asynchronous bouncy button, active-high
//   press        one-cycle pulse on an accepted 0->1 debounced transition
//
// alu_op_sel : mode FSM (IDLE/ADD/SUB) plus operand capture
//   btn_add_raw, btn_sub_raw   raw push-buttons
//   sw_a, sw_b, sw_cin         quasi-static operand switches, sampled on capture only
//   A, B, Cin                  registered operands to the arithmetic unit
//   btn1, btn2                 mutually exclusive ADD / SUB mode levels
//   load_pulse                 high the cycle new operands/mode first appear

module alu_op_sel_btn #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       vld;
    logic             deb;
    logic             deb_q;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            vld   <= 2'b00;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // sync2 only reflects the real button once both flops have
            // refilled after reset; until then its 0 is the reset value.
            vld   <= {vld[0], 1'b1};
            deb_q <= deb;
            // A button held through reset must be seen released before
            // its next rising edge counts as a press.
            if (vld[1] && !sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != deb) begin
                if (cnt == CNT_LAST) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = deb & ~deb_q & armed;
endmodule

module alu_op_sel #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_add_raw,
    input  logic       btn_sub_raw,
    input  logic [1:0] sw_a,
    input  logic [1:0] sw_b,
    input  logic       sw_cin,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic       Cin,
    output logic       btn1,
    output logic       btn2,
    output logic       load_pulse
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_SUB  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   press_add;
    logic   press_sub;
    logic   load;

    alu_op_sel_btn #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_btn_add (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_add_raw),
        .press (press_add)
    );

    alu_op_sel_btn #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_btn_sub (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_sub_raw),
        .press (press_sub)
    );

    always_comb begin
        state_next = state;
        if (press_add && press_sub) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press_add)      state_next = ST_ADD;
                    else if (press_sub) state_next = ST_SUB;
                end
                ST_ADD: begin
                    if (press_sub)      state_next = ST_SUB;
                    else if (press_add) state_next = ST_IDLE;
                end
                ST_SUB: begin
                    if (press_add)      state_next = ST_ADD;
                    else if (press_sub) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
        // Operands are captured only when entering an active mode.
        load = (state_next != state) && (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            btn1       <= 1'b0;
            btn2       <= 1'b0;
            load_pulse <= 1'b0;
            A          <= 2'b00;
            B          <= 2'b00;
            Cin        <= 1'b0;
        end else begin
            state      <= state_next;
            btn1       <= (state_next == ST_ADD);
            btn2       <= (state_next == ST_SUB);
            load_pulse <= load;
            if (load) begin
                A   <= sw_a;
                B   <= sw_b;
                Cin <= sw_cin;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sel.sv
// tb/tb_alu_op_sel.sv - directed self-checking bench for alu_op_sel
module tb_alu_op_sel;
    logic       clk;
    logic       rst_n;
    logic       btn_add_raw;
    logic       btn_sub_raw;
    logic [1:0] sw_a;
    logic [1:0] sw_b;
    logic       sw_cin;
    logic [1:0] A;
    logic [1:0] B;
    logic       Cin;
    logic       btn1;
    logic       btn2;
    logic       load_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int lp_count = 0;

    alu_op_sel #(.DEB_CYCLES(4), .CNT_W(20)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_add_raw (btn_add_raw),
        .btn_sub_raw (btn_sub_raw),
        .sw_a        (sw_a),
        .sw_b        (sw_b),
        .sw_cin      (sw_cin),
        .A           (A),
        .B           (B),
        .Cin         (Cin),
        .btn1        (btn1),
        .btn2        (btn2),
        .load_pulse  (load_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_pulse === 1'b1) lp_count++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_btns(input logic add, input logic sub, input int hold);
        btn_add_raw = add;
        btn_sub_raw = sub;
        tick(hold);
        btn_add_raw = 1'b0;
        btn_sub_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn_add_raw = 1'b0;
        btn_sub_raw = 1'b0;
        sw_a = 2'b11; sw_b = 2'b11; sw_cin = 1'b1;
        tick(3);
        n_checks++;
        if ({A, B, Cin, btn1, btn2, load_pulse} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000", {A, B, Cin, btn1, btn2, load_pulse});
        end
        rst_n = 1'b1;
        tick(5);
        n_checks++;
        if ({A, B, Cin, btn1, btn2, load_pulse} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_exit: got %b expected 00000000", {A, B, Cin, btn1, btn2, load_pulse});
        end
    endtask

    task automatic test_bounce;
        int lp0;
        int bad;
        lp0 = lp_count;
        bad = 0;
        for (int p = 0; p < 4; p++) begin
            btn_add_raw = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                if (btn1 !== 1'b0 || btn2 !== 1'b0) bad++;
            end
            btn_add_raw = 1'b0;
            tick(1);
            if (btn1 !== 1'b0 || btn2 !== 1'b0) bad++;
        end
        tick(10);
        n_checks++;
        if (bad != 0 || btn1 !== 1'b0 || btn2 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_mode: bad=%0d btn1=%b btn2=%b expected 0 0 0", bad, btn1, btn2);
        end
        n_checks++;
        if (lp_count - lp0 != 0) begin
            n_fail++;
            $display("FAIL bounce_load_pulse: got %0d pulses expected 0", lp_count - lp0);
        end
    endtask

    task automatic test_add_latency;
        int lp0;
        lp0 = lp_count;
        sw_a = 2'b10; sw_b = 2'b01; sw_cin = 1'b0;
        btn_add_raw = 1'b1;
        tick(6);
        n_checks++;
        if (btn1 !== 1'b0 || load_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL add_early: btn1=%b load_pulse=%b expected 0 0 at edge 6", btn1, load_pulse);
        end
        tick(1);
        n_checks++;
        if ({btn1, btn2, A, B, Cin, load_pulse} !== {1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_edge7: got btn1=%b btn2=%b A=%0d B=%0d Cin=%b lp=%b expected 1 0 2 1 0 1",
                     btn1, btn2, A, B, Cin, load_pulse);
        end
        tick(1);
        n_checks++;
        if (load_pulse !== 1'b0 || btn1 !== 1'b1) begin
            n_fail++;
            $display("FAIL add_pulse_width: lp=%b btn1=%b expected 0 1", load_pulse, btn1);
        end
        tick(2);
        btn_add_raw = 1'b0;
        tick(10);
        n_checks++;
        if (lp_count - lp0 != 1 || btn1 !== 1'b1 || A !== 2'd2) begin
            n_fail++;
            $display("FAIL add_release: pulses=%0d btn1=%b A=%0d expected 1 1 2", lp_count - lp0, btn1, A);
        end
    endtask

    task automatic test_sub_and_idle;
        int lp0;
        lp0 = lp_count;
        sw_a = 2'b11; sw_b = 2'b11; sw_cin = 1'b1;
        press_btns(1'b0, 1'b1, 8);
        n_checks++;
        if ({btn1, btn2, A, B, Cin} !== {1'b0, 1'b1, 2'd3, 2'd3, 1'b1} || lp_count - lp0 != 1) begin
            n_fail++;
            $display("FAIL add_to_sub: got btn1=%b btn2=%b A=%0d B=%0d Cin=%b pulses=%0d expected 0 1 3 3 1 1",
                     btn1, btn2, A, B, Cin, lp_count - lp0);
        end
        lp0 = lp_count;
        sw_a = 2'b00; sw_b = 2'b00; sw_cin = 1'b0;
        press_btns(1'b0, 1'b1, 8);
        n_checks++;
        if ({btn1, btn2, A, B, Cin} !== {1'b0, 1'b0, 2'd3, 2'd3, 1'b1} || lp_count - lp0 != 0) begin
            n_fail++;
            $display("FAIL sub_to_idle: got btn1=%b btn2=%b A=%0d B=%0d Cin=%b pulses=%0d expected 0 0 3 3 1 0",
                     btn1, btn2, A, B, Cin, lp_count - lp0);
        end
    endtask

    task automatic test_conflict;
        int lp0;
        sw_a = 2'b01; sw_b = 2'b10; sw_cin = 1'b0;
        press_btns(1'b1, 1'b0, 8);
        n_checks++;
        if (btn1 !== 1'b1 || A !== 2'd1 || B !== 2'd2) begin
            n_fail++;
            $display("FAIL conflict_setup: btn1=%b A=%0d B=%0d expected 1 1 2", btn1, A, B);
        end
        lp0 = lp_count;
        press_btns(1'b1, 1'b1, 8);
        n_checks++;
        if (btn1 !== 1'b0 || btn2 !== 1'b0 || lp_count - lp0 != 0 || A !== 2'd1) begin
            n_fail++;
            $display("FAIL conflict_idle: btn1=%b btn2=%b pulses=%0d A=%0d expected 0 0 0 1",
                     btn1, btn2, lp_count - lp0, A);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int lp0;
        sw_a = 2'b11; sw_b = 2'b01; sw_cin = 1'b1;
        btn_add_raw = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        n_checks++;
        if ({A, B, Cin, btn1, btn2, load_pulse} !== 8'b0) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %b expected 00000000", {A, B, Cin, btn1, btn2, load_pulse});
        end
        lp0 = lp_count;
        rst_n = 1'b1;
        tick(15);
        n_checks++;
        if (btn1 !== 1'b0 || btn2 !== 1'b0 || lp_count - lp0 != 0) begin
            n_fail++;
            $display("FAIL held_through_reset: btn1=%b btn2=%b pulses=%0d expected 0 0 0",
                     btn1, btn2, lp_count - lp0);
        end
        btn_add_raw = 1'b0;
        tick(10);
        press_btns(1'b1, 1'b0, 8);
        n_checks++;
        if ({btn1, btn2, A, B, Cin} !== {1'b1, 1'b0, 2'd3, 2'd1, 1'b1} || lp_count - lp0 != 1) begin
            n_fail++;
            $display("FAIL repress_after_reset: got btn1=%b btn2=%b A=%0d B=%0d Cin=%b pulses=%0d expected 1 0 3 1 1 1",
                     btn1, btn2, A, B, Cin, lp_count - lp0);
        end
    endtask

    task automatic test_switch_no_effect;
        logic [1:0] va [4];
        logic [1:0] vb [4];
        int bad;
        int lp0;
        va[0] = 2'd0; va[1] = 2'd3; va[2] = 2'd1; va[3] = 2'd2;
        vb[0] = 2'd3; vb[1] = 2'd0; vb[2] = 2'd2; vb[3] = 2'd1;
        sw_a = 2'b10; sw_b = 2'b11; sw_cin = 1'b0;
        press_btns(1'b0, 1'b1, 8);
        n_checks++;
        if ({btn1, btn2, A, B, Cin} !== {1'b0, 1'b1, 2'd2, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL enter_sub: got btn1=%b btn2=%b A=%0d B=%0d Cin=%b expected 0 1 2 3 0",
                     btn1, btn2, A, B, Cin);
        end
        lp0 = lp_count;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            sw_a = va[i];
            sw_b = vb[i];
            sw_cin = ~sw_cin;
            tick(3);
            if ({btn1, btn2, A, B, Cin, load_pulse} !== {1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0}) bad++;
        end
        n_checks++;
        if (bad != 0 || lp_count - lp0 != 0) begin
            n_fail++;
            $display("FAIL switch_no_effect: bad=%0d pulses=%0d expected 0 0", bad, lp_count - lp0);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_add_latency();
        test_sub_and_idle();
        test_conflict();
        test_reset_mid_debounce();
        test_switch_no_effect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
